alu_req_arbiter: RTL and testbench

Shares one ALU instance between `NUM_REQ` requesters, for example the execute stage and a branch/address helper, using per-requester valid/ready request and response handshakes. The block round-robin-arbitrates pending requests and registers the winner's operands and opcode. It drives the shared ALU from those registers for one cycle, captures the result, and holds it on the response channel until the owner accepts it. It sits between the requesters and the ALU in the datapath; the ALU itself stays purely combinational.

---
 rtl/singlecycle_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/alu_req_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// rtl/singlecycle_pkg.sv - shared types for the single-cycle core and its ALU request arbiter
//
// Purpose : ALU opcode enum, arbiter FSM state enum and arbiter limits.
// Ports   : none (package).
package singlecycle_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } ALUSel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } arb_state_e;

    localparam int ALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose : picks the first asserted request at or after i_ptr, wrapping around.
// Ports   : i_req   request vector
//           i_ptr   index with highest priority this cycle
//           i_en    grant enable; no grant when low
//           o_grant one-hot grant (zero when nothing granted)
//           o_idx   encoded index of the grant (0 when nothing granted)
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Walk the requesters starting at the pointer so the most recent
            // winner gets lowest priority next time.
            w_cand = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && !w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - shares one combinational ALU between NUM_REQ requesters
//
// Purpose : round-robin accepts a request, drives the ALU from registered
//           operands for one cycle, captures the result and holds it for
//           the owning requester until it is accepted.
// Ports   : i_clk, i_rst_n                      clock, async active-low reset
//           i_req_valid/o_req_ready             per-requester request handshake
//           i_req_operand_a/_b, i_req_alu_op    per-requester request payload
//           o_rsp_valid/i_rsp_ready             per-requester response handshake
//           o_rsp_res                           shared response data
//           o_alu_operand_a/_b, o_alu_op        to the shared ALU
//           i_alu_res                           from the shared ALU
module alu_req_arbiter
    import singlecycle_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0][31:0]  i_req_operand_a,
    input  logic [NUM_REQ-1:0][31:0]  i_req_operand_b,
    input  ALUSel_e [NUM_REQ-1:0]     i_req_alu_op,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic [31:0]               o_rsp_res,
    output logic [31:0]               o_alu_operand_a,
    output logic [31:0]               o_alu_operand_b,
    output ALUSel_e                   o_alu_op,
    input  logic [31:0]               i_alu_res
);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_owner;
    logic [31:0]   r_op_a;
    logic [31:0]   r_op_b;
    ALUSel_e       r_op;
    logic [31:0]   r_res;

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_owner_ack;
    logic               w_window;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_rsp_valid;

    // Only the owner's ready bit completes a response.
    assign w_owner_ack = (r_state == S_RESP) && i_rsp_ready[r_owner];

    // Accepting while the current response retires gives one transaction
    // every two cycles. Gating with reset keeps o_req_ready low in reset.
    assign w_window = i_rst_n && ((r_state == S_IDLE) || w_owner_ack);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .i_en    (w_window),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_accept = |w_grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_owner_ack) w_state_nxt = w_accept ? S_EXEC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op     <= ALU_ADD;
            r_res    <= '0;
        end else begin
            if (w_accept) begin
                r_op_a   <= i_req_operand_a[w_idx];
                r_op_b   <= i_req_operand_b[w_idx];
                r_op     <= i_req_alu_op[w_idx];
                r_owner  <= w_idx;
                r_rr_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
            end
            if (r_state == S_EXEC) begin
                r_res <= i_alu_res;
            end
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        if (r_state == S_RESP) begin
            w_rsp_valid[r_owner] = 1'b1;
        end
    end

    assign o_req_ready     = w_grant;
    assign o_rsp_valid     = w_rsp_valid;
    assign o_rsp_res       = r_res;
    assign o_alu_operand_a = r_op_a;
    assign o_alu_operand_b = r_op_b;
    assign o_alu_op        = r_op;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - self-checking bench for alu_req_arbiter with a response scoreboard
module tb_alu_req_arbiter;
    import singlecycle_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0][31:0]  req_a = '0;
    logic [1:0][31:0]  req_b = '0;
    ALUSel_e [1:0]     req_op;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready = '0;
    logic [31:0]       rsp_res;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    ALUSel_e           alu_op;
    logic [31:0]       alu_res;

    typedef struct {
        int          owner;
        logic [31:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    int          rsp_cyc[$];
    logic [31:0] exp_tab [2];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          mon_own;
    exp_t        mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_req_arbiter #(.NUM_REQ(2)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_operand_a (req_a),
        .i_req_operand_b (req_b),
        .i_req_alu_op    (req_op),
        .o_req_ready     (req_ready),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_res       (rsp_res),
        .o_alu_operand_a (alu_a),
        .o_alu_operand_b (alu_b),
        .o_alu_op        (alu_op),
        .i_alu_res       (alu_res)
    );

    // Stand-in for the shared combinational ALU.
    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, ALUSel_e op);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

    assign alu_res = alu_f(alu_a, alu_b, alu_op);

    // Scoreboard: accepted requests push their expected result; retired
    // responses pop and compare owner and data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid != 2'b00) begin
                n_checks++;
                if ($countones(rsp_valid) != 1) $display("FAIL rsp_onehot got=%b exp=one-hot", rsp_valid);
                else n_pass++;
                mon_own = rsp_valid[1] ? 1 : 0;
                if (rsp_ready[mon_own]) begin
                    rsp_cyc.push_back(cyc);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected got owner=%0d res=%h exp=no response", mon_own, rsp_res);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_own !== mon_e.owner || rsp_res !== mon_e.res)
                            $display("FAIL sb_rsp got owner=%0d res=%h exp owner=%0d res=%h",
                                     mon_own, rsp_res, mon_e.owner, mon_e.res);
                        else n_pass++;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back('{i, exp_tab[i]});
                    grant_log.push_back(i);
                end
            end
        end
    end

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = ALU_SUB;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); else n_pass++;
        n_checks++; if (rsp_res !== 32'h0) $display("FAIL reset_rsp_res got=%h exp=0", rsp_res); else n_pass++;
        n_checks++; if (alu_op !== ALU_ADD) $display("FAIL reset_alu_op got=%0d exp=%0d", alu_op, ALU_ADD); else n_pass++;
        n_checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) $display("FAIL reset_alu_operands got=%h/%h exp=0/0", alu_a, alu_b); else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        bit ok;
        @(posedge clk); #1;
        req_a[0] = 32'd5; req_b[0] = 32'd3; req_op[0] = ALU_ADD; exp_tab[0] = 32'h8;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) $display("FAIL add_req_ready got=%b exp=01", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) $display("FAIL add_exec_rsp_valid got=%b exp=00", rsp_valid); else n_pass++;
        n_checks++;
        if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== ALU_ADD)
            $display("FAIL add_alu_drive got=%h/%h/%0d exp=5/3/%0d", alu_a, alu_b, alu_op, ALU_ADD);
        else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b01) $display("FAIL add_rsp_valid got=%b exp=01", rsp_valid); else n_pass++;
        n_checks++; if (rsp_res !== 32'h8) $display("FAIL add_rsp_res got=%h exp=00000008", rsp_res); else n_pass++;
        drain(ok);
        n_checks++; if (!ok) $display("FAIL add_drain got=%0d pending exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrong_owner();
        bit ok;
        bit seen;
        @(posedge clk); #1;
        req_a[1] = 32'd1; req_b[1] = 32'd2; req_op[1] = ALU_ADD; exp_tab[1] = 32'h3;
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) $display("FAIL wo_req_ready got=%b exp=10", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL wo_rsp_timeout got=no response exp=response"); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 2'b10 || rsp_res !== 32'h3)
                $display("FAIL wo_hold got=%b/%h exp=10/00000003", rsp_valid, rsp_res);
            else n_pass++;
        end
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        drain(ok);
        n_checks++; if (!ok) $display("FAIL wo_drain got=%0d pending exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_contention();
        bit ok;
        bit done;
        @(posedge clk); #1;
        req_a[0] = 32'd10;         req_b[0] = 32'd3; req_op[0] = ALU_SUB; exp_tab[0] = 32'h00000007;
        req_a[1] = 32'h80000000;   req_b[1] = 32'd4; req_op[1] = ALU_SRA; exp_tab[1] = 32'hF8000000;
        rsp_ready = 2'b11;
        grant_log.delete();
        req_valid = 2'b11;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (grant_log.size() >= 4) begin
                req_valid = 2'b00;
                done = 1'b1;
            end
        end
        req_valid = 2'b00;
        n_checks++; if (!done) $display("FAIL cont_grants got=%0d exp=4", grant_log.size()); else n_pass++;
        drain(ok);
        n_checks++; if (!ok) $display("FAIL cont_drain got=%0d pending exp=0", exp_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            n_checks++;
            if (grant_log[i] !== i % 2) $display("FAIL cont_order[%0d] got=%0d exp=%0d", i, grant_log[i], i % 2);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit ok;
        @(posedge clk); #1;
        req_a[1] = 32'd1;  req_b[1] = 32'hFFFFFFFF; req_op[1] = ALU_SLTU; exp_tab[1] = 32'h1;
        req_a[0] = 32'h10; req_b[0] = 32'h20;       req_op[0] = ALU_ADD;  exp_tab[0] = 32'h30;
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) $display("FAIL stall_req1_ready got=%b exp=10", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) $display("FAIL stall_exec_ready got=%b exp=00", req_ready); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b10 || rsp_res !== 32'h1)
                $display("FAIL stall_hold[%0d] got ready=%b valid=%b res=%h exp ready=00 valid=10 res=00000001",
                         k, req_ready, rsp_valid, rsp_res);
            else n_pass++;
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01 || rsp_valid !== 2'b10)
            $display("FAIL stall_release got ready=%b valid=%b exp ready=01 valid=10", req_ready, rsp_valid);
        else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain(ok);
        n_checks++; if (!ok) $display("FAIL stall_drain got=%0d pending exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit done;
        @(posedge clk); #1;
        req_a[0] = 32'h1234; req_b[0] = 32'h1111; req_op[0] = ALU_XOR; exp_tab[0] = 32'h0325;
        rsp_ready = 2'b11;
        rsp_cyc.delete();
        req_valid = 2'b01;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (rsp_cyc.size() >= 4) begin
                req_valid = 2'b00;
                done = 1'b1;
            end
        end
        req_valid = 2'b00;
        n_checks++; if (!done) $display("FAIL b2b_count got=%0d exp=4", rsp_cyc.size()); else n_pass++;
        drain(ok);
        n_checks++; if (!ok) $display("FAIL b2b_drain got=%0d pending exp=0", exp_q.size()); else n_pass++;
        for (int i = 1; i < 4 && i < rsp_cyc.size(); i++) begin
            n_checks++;
            if (rsp_cyc[i] - rsp_cyc[i-1] !== 2)
                $display("FAIL b2b_gap[%0d] got=%0d exp=2", i, rsp_cyc[i] - rsp_cyc[i-1]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        @(posedge clk); #1;
        req_a[0] = 32'd5; req_b[0] = 32'd3; req_op[0] = ALU_SUB; exp_tab[0] = 32'h2;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) $display("FAIL mr_req_ready got=%b exp=01", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (alu_op !== ALU_SUB) $display("FAIL mr_exec_op got=%0d exp=%0d", alu_op, ALU_SUB); else n_pass++;
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        exp_q.delete();
        #1;
        n_checks++;
        if (rsp_valid !== 2'b00 || rsp_res !== 32'h0 || req_ready !== 2'b00)
            $display("FAIL mr_outputs got valid=%b res=%h ready=%b exp 00/0/00", rsp_valid, rsp_res, req_ready);
        else n_pass++;
        n_checks++;
        if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== ALU_ADD)
            $display("FAIL mr_alu got=%h/%h/%0d exp=0/0/%0d", alu_a, alu_b, alu_op, ALU_ADD);
        else n_pass++;
        req_a[0] = 32'd7; req_b[0] = 32'd8; req_op[0] = ALU_ADD; exp_tab[0] = 32'd15;
        req_a[1] = 32'd1; req_b[1] = 32'd1; req_op[1] = ALU_ADD; exp_tab[1] = 32'd2;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) $display("FAIL mr_first_grant got=%b exp=01", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain(ok);
        n_checks++; if (!ok) $display("FAIL mr_drain got=%0d pending exp=0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_op[0] = ALU_ADD;
        req_op[1] = ALU_ADD;
        exp_tab[0] = '0;
        exp_tab[1] = '0;
        test_reset();
        test_single_add();
        test_wrong_owner();
        test_contention();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
